// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART types and default frame parameters
// Used by both the receive and transmit paths.
package usart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int USART_DATA_BITS  = 8;
   localparam int USART_OVERSAMPLE = 16;
   localparam int USART_DIV_W      = 12;

endpackage

// File: rtl/usart_rx_core_if.sv
// rtl/usart_rx_core_if.sv - bus-side receive buffer handshake
// The receiver is the master; the consumer takes rx_data and pulses rx_ack.
interface usart_rx_core_if #(
   parameter int DATA_BITS = usart_pkg::USART_DATA_BITS
) ();

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 rx_ack;

   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output overrun,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  overrun,
      output rx_ack
   );

endinterface

// File: rtl/usart_baud_tick.sv
// rtl/usart_baud_tick.sv - oversampling tick divider shared by rx and tx
// Held at zero while idle; the divisor is only picked up on a reload so a change never shortens a tick.
module usart_baud_tick #(
   parameter int DIV_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_q;

   assign tick = run && (cnt == div_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         div_q <= '0;
      end else if (!run || tick) begin
         cnt   <= '0;
         div_q <= div;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/usart_rx_core.sv
// rtl/usart_rx_core.sv - asynchronous 8N1/8E1/8O1 receiver with one-entry holding register
// Oversampled start-edge detection, mid-bit sampling, parity/framing/overrun reporting.
module usart_rx_core
   import usart_pkg::*;
#(
   parameter int DATA_BITS  = USART_DATA_BITS,
   parameter int OVERSAMPLE = USART_OVERSAMPLE,
   parameter int DIV_W      = USART_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx,
   input  logic             rx_en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             parity_en,
   input  logic             parity_odd,
   output logic             busy,
   usart_rx_core_if.master  bus
);

   localparam int SCNT_W = $clog2(OVERSAMPLE);
   localparam int BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

   logic                 rx_m;
   logic                 rx_s;
   logic                 rx_p;
   rx_state_t            state;
   rx_state_t            state_nxt;
   logic [SCNT_W-1:0]    scnt;
   logic [BIDX_W-1:0]    bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr;
   logic                 done;
   logic                 stop_bit;
   logic                 tick;
   logic                 run;
   logic                 fall;
   logic                 half_pt;
   logic                 mid_pt;
   logic                 clr;
   logic                 shift_en;
   logic                 par_en;
   logic                 stop_en;

   assign run     = rx_en && (state != IDLE);
   assign fall    = rx_p & ~rx_s;
   assign half_pt = tick && (scnt == SCNT_HALF);
   assign mid_pt  = tick && (scnt == SCNT_LAST);
   assign busy    = (state != IDLE);

   usart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .div   (baud_div),
      .tick  (tick)
   );

   // Idle-high reset so a line that is already idle never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_p <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      if (!rx_en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (fall) begin
                  state_nxt = START;
                  clr       = 1'b1;
               end
            end
            START: begin
               if (half_pt) begin
                  if (rx_s) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = DATA;
                     clr       = 1'b1;
                  end
               end
            end
            DATA: begin
               if (mid_pt) begin
                  shift_en = 1'b1;
                  if (bidx == BIDX_LAST) begin
                     state_nxt = parity_en ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (mid_pt) begin
                  par_en    = 1'b1;
                  state_nxt = STOP;
               end
            end
            STOP: begin
               // Leaving at mid stop bit lets the next start edge be caught early.
               if (mid_pt) begin
                  stop_en   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt     <= '0;
         bidx     <= '0;
         shreg    <= '0;
         perr     <= 1'b0;
         done     <= 1'b0;
         stop_bit <= 1'b0;
      end else begin
         if (clr) begin
            scnt <= '0;
         end else if (tick) begin
            scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
         end
         if (clr) begin
            bidx <= '0;
         end else if (shift_en) begin
            bidx <= bidx + 1'b1;
         end
         if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         end
         if (clr) begin
            perr <= 1'b0;
         end else if (par_en) begin
            perr <= ^shreg ^ rx_s ^ parity_odd;
         end
         done <= stop_en;
         if (stop_en) begin
            stop_bit <= rx_s;
         end
      end
   end

   // Holding register: an unacknowledged full buffer keeps the old frame and flags the loss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.overrun    <= 1'b0;
      end else if (done) begin
         if (bus.rx_valid && !bus.rx_ack) begin
            bus.overrun <= 1'b1;
         end else begin
            bus.rx_data    <= shreg;
            bus.rx_valid   <= 1'b1;
            bus.parity_err <= perr & parity_en;
            bus.frame_err  <= ~stop_bit;
            if (bus.rx_ack) begin
               bus.overrun <= 1'b0;
            end
         end
      end else if (bus.rx_ack && bus.rx_valid) begin
         bus.rx_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.overrun    <= 1'b0;
      end
   end

endmodule
